// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank arbiter.
// Op encoding doubles as the {J,K} pair driven onto selected bits.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_ACK
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    function automatic logic op_j(input jk_op_e op);
        return (op == OP_SET) || (op == OP_TOGGLE);
    endfunction

    function automatic logic op_k(input jk_op_e op);
        return (op == OP_CLEAR) || (op == OP_TOGGLE);
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_cell.sv
// Single synchronous JK flip-flop with synchronous active-high reset.
module jk_cell (
    input  logic CLK,
    input  logic RESET,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q <= 1'b0;
        end else begin
            unique case ({J, K})
                2'b00:   Q <= Q;
                2'b01:   Q <= 1'b0;
                2'b10:   Q <= 1'b1;
                default: Q <= ~Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK flip-flops between two requesters.
// Each accepted command occupies IDLE -> APPLY -> ACK, one cycle each.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_mask,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_mask,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    state_e           state_q;
    logic             last_q;
    jk_op_e           op_q;
    logic [WIDTH-1:0] mask_q;
    logic             id_q;
    logic             done_q;
    logic             done_id_q;

    logic             idle;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign idle = (state_q == S_IDLE);

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        a_ready = idle && !RESET && a_valid
                  && (!b_valid || last_q == ID_B);
        b_ready = idle && !RESET && b_valid
                  && (!a_valid || last_q == ID_A);
    end

    always_comb begin
        j = '0;
        k = '0;
        if (state_q == S_APPLY) begin
            j = mask_q & {WIDTH{op_j(op_q)}};
            k = mask_q & {WIDTH{op_k(op_q)}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            last_q    <= ID_B;
            op_q      <= OP_HOLD;
            mask_q    <= '0;
            id_q      <= ID_A;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (a_ready || b_ready) begin
                        state_q <= S_APPLY;
                        op_q    <= a_ready ? jk_op_e'(a_op)
                                           : jk_op_e'(b_op);
                        mask_q  <= a_ready ? a_mask : b_mask;
                        id_q    <= b_ready;
                        last_q  <= b_ready;
                    end
                end
                S_APPLY: begin
                    state_q   <= S_ACK;
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .CLK   (CLK),
            .RESET (RESET),
            .J     (j[i]),
            .K     (k[i]),
            .Q     (Q[i])
        );
    end

    assign busy    = !idle;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed cases plus
// randomized traffic against a behavioural bank/arbitration model.
module tb_jk_bank_arbiter;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [1:0]   a_op = 2'b00;
    logic [W-1:0] a_mask = '0;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [1:0]   b_op = 2'b00;
    logic [W-1:0] b_mask = '0;
    logic [W-1:0] Q;
    logic         busy;
    logic         done;
    logic         done_id;

    always #5 CLK = ~CLK;

    jk_bank_arbiter #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_op    (a_op),
        .a_mask  (a_mask),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_op    (b_op),
        .b_mask  (b_mask),
        .Q       (Q),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: bank value, cycles left in the current command,
    // the pending command and the last requester granted.
    logic [W-1:0] m_q = '0;
    int           m_left = 0;
    logic [1:0]   m_op = 2'b00;
    logic [W-1:0] m_mask = '0;
    logic         m_id = 1'b0;
    logic         m_last = 1'b1;

    int cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    logic obs_a, obs_b;
    int   log_id[$];
    int   log_cyc[$];

    task automatic step(input logic rst,
                        input logic av, input logic [1:0] aop,
                        input logic [W-1:0] am,
                        input logic bv, input logic [1:0] bop,
                        input logic [W-1:0] bm);
        logic ea, eb;
        @(negedge CLK);
        RESET = rst;
        a_valid = av; a_op = aop; a_mask = am;
        b_valid = bv; b_op = bop; b_mask = bm;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (!rst && m_left == 0) begin
            if (av && (!bv || m_last == 1'b1)) ea = 1'b1;
            else if (bv) eb = 1'b1;
        end
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("excl", a_ready & b_ready, 0);
        chk("busy", busy, m_left != 0);
        chk("done", done, m_left == 1);
        if (m_left == 1) chk("done_id", done_id, m_id);
        chk("q", Q, m_q);
        obs_a = a_ready & av;
        obs_b = b_ready & bv;
        if (done) n_done++;
        if (obs_a || obs_b) begin
            n_acc++;
            log_id.push_back(obs_b ? 1 : 0);
            log_cyc.push_back(cyc);
        end
        cyc++;
        if (rst) begin
            m_q = '0;
            m_left = 0;
            m_last = 1'b1;
        end else if (m_left == 0) begin
            if (ea || eb) begin
                m_left = 2;
                m_op = ea ? aop : bop;
                m_mask = ea ? am : bm;
                m_id = eb;
                m_last = eb;
            end
        end else if (m_left == 2) begin
            case (m_op)
                2'b01: m_q = m_q & ~m_mask;
                2'b10: m_q = m_q | m_mask;
                2'b11: m_q = m_q ^ m_mask;
                default: m_q = m_q;
            endcase
            m_left = 1;
        end else begin
            m_left = 0;
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 2'b00, '0, 1'b0, 2'b00, '0);
    endtask

    // Issue one command from a single requester; returns in the ACK cycle.
    task automatic cmd(input logic id, input logic [1:0] op,
                       input logic [W-1:0] m);
        if (id) step(1'b0, 1'b0, 2'b00, '0, 1'b1, op, m);
        else    step(1'b0, 1'b1, op, m, 1'b0, 2'b00, '0);
        idle_step();
        idle_step();
    endtask

    logic         pa, pb;
    logic [1:0]   ra_op, rb_op;
    logic [W-1:0] ra_m, rb_m;
    int           acc0;

    initial begin
        // 1: reset, then A SET 0F
        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 2'b00, '0);
        chk("rst_q", Q, 8'h00);
        idle_step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step(1'b0, 1'b1, 2'b10, 8'h0F, 1'b0, 2'b00, '0);
        chk("t1_ready", a_ready, 1);
        idle_step();
        idle_step();
        chk("t1_q", Q, 8'h0F);
        chk("t1_done", done, 1);
        chk("t1_id", done_id, 0);
        idle_step();
        chk("t1_busy", busy, 0);

        // 2: B toggles all, A clears upper nibble
        cmd(1'b1, 2'b11, 8'hFF);
        chk("t2_q_tog", Q, 8'hF0);
        chk("t2_id_b", done_id, 1);
        cmd(1'b0, 2'b01, 8'hF0);
        chk("t2_q_clr", Q, 8'h00);

        // 3: both valid continuously after reset
        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 2'b00, '0);
        log_id.delete();
        log_cyc.delete();
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, 2'b10, 8'h01, 1'b1, 2'b10, 8'h02);
        chk("t3_nacc", log_id.size(), 4);
        if (log_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_order", log_id[i], i % 2);
                if (i > 0)
                    chk("t3_gap", log_cyc[i] - log_cyc[i-1], 3);
            end
        end
        idle_step();
        idle_step();
        chk("t3_q", Q, 8'h03);

        // 4: HOLD and empty-mask commands leave Q alone
        cmd(1'b0, 2'b01, 8'hFF);
        cmd(1'b0, 2'b10, 8'h5A);
        cmd(1'b0, 2'b00, 8'hFF);
        chk("t4_hold_done", done, 1);
        chk("t4_hold_q", Q, 8'h5A);
        cmd(1'b0, 2'b11, 8'h00);
        chk("t4_m0_done", done, 1);
        chk("t4_m0_q", Q, 8'h5A);

        // 5: reset during APPLY discards the command
        step(1'b0, 1'b1, 2'b10, 8'hFF, 1'b0, 2'b00, '0);
        step(1'b1, 1'b0, 2'b00, '0, 1'b0, 2'b00, '0);
        idle_step();
        chk("t5_q", Q, 8'h00);
        chk("t5_done", done, 0);
        chk("t5_busy", busy, 0);
        cmd(1'b1, 2'b10, 8'h3C);
        chk("t5_b_done", done, 1);
        chk("t5_b_id", done_id, 1);
        chk("t5_b_q", Q, 8'h3C);
        idle_step();

        // 6: randomized traffic
        n_acc = 0;
        n_done = 0;
        pa = 1'b0;
        pb = 1'b0;
        ra_op = 2'b00; rb_op = 2'b00;
        ra_m = '0; rb_m = '0;
        acc0 = cyc;
        while (n_acc < 1000 && cyc - acc0 < 20000) begin
            if (!pa && $urandom_range(0, 2) == 0) begin
                pa = 1'b1;
                ra_op = 2'($urandom_range(0, 3));
                ra_m = W'($urandom);
            end else if (pa && $urandom_range(0, 15) == 0) begin
                pa = 1'b0;
            end
            if (!pb && $urandom_range(0, 2) == 0) begin
                pb = 1'b1;
                rb_op = 2'($urandom_range(0, 3));
                rb_m = W'($urandom);
            end else if (pb && $urandom_range(0, 15) == 0) begin
                pb = 1'b0;
            end
            step(1'b0, pa, ra_op, ra_m, pb, rb_op, rb_m);
            if (obs_a) pa = 1'b0;
            if (obs_b) pb = 1'b0;
        end
        chk("rand_timeout", n_acc >= 1000, 1);
        for (int i = 0; i < 3; i++) idle_step();
        chk("done_vs_acc", n_done, n_acc);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
